ex_muldiv_unit: RTL and testbench

- Consumer at the EX end of the ID/EX pipeline register. It takes the registered operands, destination register and operation, and computes unsigned RV32M-style multiply/divide iteratively over 32 cycles.
- It drives a stall back to the ID/EX and IF/ID registers while it runs. It then presents a one-cycle result with its destination register toward the EX/MEM stage.

---
 rtl/ex_muldiv_unit.sv | 105 ++++++++++
 tb/tb_ex_muldiv_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned RV32M multiply/divide unit sitting after the ID/EX register.
// Stalls the front end while it runs and presents a one-cycle result toward EX/MEM.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] data_1_in,
    input  logic [WIDTH-1:0] data_2_in,
    input  logic [4:0]       Rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             valid_out,
    output logic [WIDTH-1:0] result_out,
    output logic [4:0]       Rd_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op;
    logic [4:0]         rd;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     add_sum, rem_sh, diff;
    logic               accept, last;

    assign accept = (state == IDLE) && valid_in && !flush;
    assign last   = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

    // acc holds {hi, lo}: product/multiplier for MUL, remainder/quotient for DIV.
    // op[0] picks the high half in both cases (MULHU, REMU).
    always_comb begin
        addend  = acc[0] ? opnd : '0;
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd};
        if (!op[1])
            acc_step = {add_sum, acc[WIDTH-1:1]};
        else if (diff[WIDTH])
            acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (valid_in) state_next = BUSY;
                BUSY:    if (last) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = accept || (state == BUSY);
        valid_out = (state == DONE) && !flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            op         <= '0;
            rd         <= '0;
            opnd       <= '0;
            acc        <= '0;
            result_out <= '0;
            Rd_out     <= '0;
        end else if (accept) begin
            cnt <= '0;
            op  <= op_in;
            rd  <= Rd_in;
            if (op_in[1]) begin
                acc  <= {{WIDTH{1'b0}}, data_1_in};
                opnd <= data_2_in;
            end else begin
                acc  <= {{WIDTH{1'b0}}, data_2_in};
                opnd <= data_1_in;
            end
        end else if ((state == BUSY) && !flush) begin
            cnt <= cnt + 1'b1;
            acc <= acc_step;
            if (last) begin
                result_out <= op[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
                Rd_out     <= rd;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: result values, latency, flush and async reset.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [1:0]  op_in;
    logic [31:0] data_1_in;
    logic [31:0] data_2_in;
    logic [4:0]  Rd_in;
    logic        flush;
    logic        busy;
    logic        valid_out;
    logic [31:0] result_out;
    logic [4:0]  Rd_out;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int acc_cyc    = 0;

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .op_in      (op_in),
        .data_1_in  (data_1_in),
        .data_2_in  (data_2_in),
        .Rd_in      (Rd_in),
        .flush      (flush),
        .busy       (busy),
        .valid_out  (valid_out),
        .result_out (result_out),
        .Rd_out     (Rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one op from an IDLE cycle and follows it to its valid_out pulse.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int  n  = 0;
        int  nb = 0;
        bit  seen = 0;
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_valid"}, {31'd0, valid_out}, 32'd0);
        op_in = op; data_1_in = a; data_2_in = b; Rd_in = rd; valid_in = 1'b1;
        #1;
        if (busy) nb++;
        acc_cyc = cyc;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (valid_out) seen = 1;
            else if (busy) nb++;
        end
        check({tag, "_latency"}, n, 32'd33);
        check({tag, "_busy_cycles"}, nb, 32'd33);
        check({tag, "_result"}, result_out, exp);
        check({tag, "_rd"}, {27'd0, Rd_out}, {27'd0, rd});
        check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        valid_in = 1'b0;
    endtask

    initial begin
        int a0;
        int pulses;
        reset = 1'b0; valid_in = 1'b0; op_in = 2'b00;
        data_1_in = '0; data_2_in = '0; Rd_in = '0; flush = 1'b0;

        @(negedge clk);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_result", result_out, 32'd0);
        check("rst_rd", {27'd0, Rd_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;

        do_op("mul_7x6",    2'b00, 32'd7,        32'd6,        5'd5,  32'd42);
        do_op("mulhu_ff",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE);
        do_op("mul_ff",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000001);
        do_op("divu_100_7", 2'b10, 32'd100,      32'd7,        5'd8,  32'd14);
        do_op("remu_100_7", 2'b11, 32'd100,      32'd7,        5'd9,  32'd2);
        do_op("divu_msb_1", 2'b10, 32'h80000000, 32'd1,        5'd10, 32'h80000000);
        do_op("divu_by_0",  2'b10, 32'd1234,     32'd0,        5'd11, 32'hFFFFFFFF);
        do_op("remu_by_0",  2'b11, 32'd1234,     32'd0,        5'd12, 32'd1234);

        // Kill a MUL once its counter reaches 10.
        @(negedge clk);
        op_in = 2'b00; data_1_in = 32'd5; data_2_in = 32'd5; Rd_in = 5'd20; valid_in = 1'b1;
        repeat (11) @(negedge clk);
        flush = 1'b1; valid_in = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_valid", {31'd0, valid_out}, 32'd0);
        check("flush_result_held", result_out, 32'd1234);
        check("flush_rd_held", {27'd0, Rd_out}, 32'd12);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        check("flush_no_pulse", pulses, 32'd0);

        // Flush in IDLE must block acceptance.
        valid_in = 1'b1; flush = 1'b1;
        #1;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        #1;
        check("idle_flush_no_accept", {31'd0, busy}, 32'd0);

        do_op("mul_after_flush", 2'b00, 32'd5, 32'd5, 5'd21, 32'd25);

        // Asynchronous reset in the middle of a BUSY run.
        @(negedge clk);
        op_in = 2'b00; data_1_in = 32'd3; data_2_in = 32'd3; Rd_in = 5'd7; valid_in = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0; valid_in = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, valid_out}, 32'd0);
        check("async_rst_result", result_out, 32'd0);
        check("async_rst_rd", {27'd0, Rd_out}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op("mul_3x4", 2'b00, 32'd3, 32'd4, 5'd1, 32'd12);
        a0 = acc_cyc;
        do_op("divu_9_2", 2'b10, 32'd9, 32'd2, 5'd2, 32'd4);
        check("accept_gap", acc_cyc - a0, 32'd34);
        @(negedge clk);
        check("single_pulse", {31'd0, valid_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
